// File: rtl/xgs_axis_frame_checker.sv
// Pass-through AXI4-Stream video checker: a 2-entry skid buffer forwards every beat
// unchanged while a small FSM checks SOF/EOL framing, line length and frame height.
module xgs_axis_frame_checker #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast,
  input  logic                    cfg_enable,
  input  logic [CNT_WIDTH-1:0]    cfg_line_words,
  input  logic [CNT_WIDTH-1:0]    cfg_frame_lines,
  input  logic                    clr_status,
  output logic                    frame_done,
  output logic [31:0]             stat_frame_cnt,
  output logic                    stat_err_no_sof,
  output logic                    stat_err_sof_early,
  output logic                    stat_err_line_short,
  output logic                    stat_err_line_long
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int BEAT_WIDTH = DATA_WIDTH + KEEP_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic {ST_IDLE, ST_IN_FRAME} state_t;

  // ---------------------------------------------------------------- skid buffer
  logic [BEAT_WIDTH-1:0] w_s_beat;
  logic [BEAT_WIDTH-1:0] r_head;
  logic [BEAT_WIDTH-1:0] r_skid;
  logic [BEAT_WIDTH-1:0] w_head_next;
  logic [BEAT_WIDTH-1:0] w_skid_next;
  logic                  r_head_vld;
  logic                  r_skid_vld;
  logic                  w_head_vld_next;
  logic                  w_skid_vld_next;
  logic                  r_s_ready;
  logic                  w_acc;
  logic                  w_pop;

  assign w_s_beat = {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  assign w_acc    = s_axis_tvalid & r_s_ready;
  assign w_pop    = r_head_vld & m_axis_tready;

  // The head register drives m_axis_*; the skid entry only fills while the head stalls.
  always_comb begin
    w_head_next     = r_head;
    w_head_vld_next = r_head_vld;
    w_skid_next     = r_skid;
    w_skid_vld_next = r_skid_vld;
    if (w_pop) begin
      if (r_skid_vld) begin
        w_head_next     = r_skid;
        w_head_vld_next = 1'b1;
        w_skid_vld_next = w_acc;
        if (w_acc) begin
          w_skid_next = w_s_beat;
        end
      end else begin
        w_head_vld_next = w_acc;
        if (w_acc) begin
          w_head_next = w_s_beat;
        end
      end
    end else if (w_acc) begin
      if (!r_head_vld) begin
        w_head_next     = w_s_beat;
        w_head_vld_next = 1'b1;
      end else begin
        w_skid_next     = w_s_beat;
        w_skid_vld_next = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_head     <= '0;
      r_skid     <= '0;
      r_head_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_s_ready  <= 1'b0;
    end else begin
      r_head     <= w_head_next;
      r_skid     <= w_skid_next;
      r_head_vld <= w_head_vld_next;
      r_skid_vld <= w_skid_vld_next;
      r_s_ready  <= ~w_skid_vld_next;
    end
  end

  assign s_axis_tready = r_s_ready;
  assign m_axis_tvalid = r_head_vld;
  assign m_axis_tdata  = r_head[DATA_WIDTH-1:0];
  assign m_axis_tkeep  = r_head[DATA_WIDTH +: KEEP_WIDTH];
  assign m_axis_tlast  = r_head[DATA_WIDTH + KEEP_WIDTH];
  assign m_axis_tuser  = r_head[DATA_WIDTH + KEEP_WIDTH + 1];

  // ---------------------------------------------------------------- geometry checker
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_word_cnt;
  logic [CNT_WIDTH-1:0] r_line_cnt;
  logic [CNT_WIDTH-1:0] r_lw;
  logic [CNT_WIDTH-1:0] r_fl;
  logic                 r_long_seen;
  logic                 r_frame_done;
  logic [31:0]          r_frame_cnt;
  logic                 r_err_no_sof;
  logic                 r_err_sof_early;
  logic                 r_err_line_short;
  logic                 r_err_line_long;

  logic                 w_in_frame;
  logic                 w_sof;
  logic [CNT_WIDTH-1:0] w_lw;
  logic [CNT_WIDTH-1:0] w_fl;
  logic [CNT_WIDTH-1:0] w_word_this;
  logic [CNT_WIDTH-1:0] w_line_this;
  logic [CNT_WIDTH-1:0] w_line_next;
  logic                 w_long_seen;
  logic                 w_chk;
  logic                 w_ev_no_sof;
  logic                 w_ev_early;
  logic                 w_ev_long;
  logic                 w_ev_short;
  logic                 w_ev_done;

  // An SOF beat is judged against the geometry being latched with it, as word 1 of line 0.
  always_comb begin
    w_in_frame  = (r_state == ST_IN_FRAME);
    w_sof       = s_axis_tuser;
    w_lw        = w_sof ? cfg_line_words  : r_lw;
    w_fl        = w_sof ? cfg_frame_lines : r_fl;
    w_word_this = w_sof ? CNT_ONE :
                  ((r_word_cnt == CNT_MAX) ? r_word_cnt : r_word_cnt + CNT_ONE);
    w_line_this = w_sof ? '0 : r_line_cnt;
    w_line_next = (w_line_this == CNT_MAX) ? w_line_this : w_line_this + CNT_ONE;
    w_long_seen = w_sof ? 1'b0 : r_long_seen;
    w_chk       = w_acc & cfg_enable & (w_sof | w_in_frame);
    w_ev_no_sof = w_acc & cfg_enable & ~w_sof & ~w_in_frame;
    w_ev_early  = w_chk & w_sof & w_in_frame;
    w_ev_long   = w_chk & ~s_axis_tlast & (w_lw != '0) & (w_word_this == w_lw) & ~w_long_seen;
    w_ev_short  = w_chk & s_axis_tlast & (w_lw != '0) & (w_word_this < w_lw);
    w_ev_done   = w_chk & s_axis_tlast & (w_fl != '0) & (w_line_next == w_fl);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state          <= ST_IDLE;
      r_word_cnt       <= '0;
      r_line_cnt       <= '0;
      r_lw             <= '0;
      r_fl             <= '0;
      r_long_seen      <= 1'b0;
      r_frame_done     <= 1'b0;
      r_frame_cnt      <= '0;
      r_err_no_sof     <= 1'b0;
      r_err_sof_early  <= 1'b0;
      r_err_line_short <= 1'b0;
      r_err_line_long  <= 1'b0;
    end else begin
      // Events in the clearing cycle survive the clear.
      r_frame_done     <= w_ev_done;
      r_frame_cnt      <= (clr_status ? 32'd0 : r_frame_cnt) + {31'd0, w_ev_done};
      r_err_no_sof     <= (r_err_no_sof     & ~clr_status) | w_ev_no_sof;
      r_err_sof_early  <= (r_err_sof_early  & ~clr_status) | w_ev_early;
      r_err_line_short <= (r_err_line_short & ~clr_status) | w_ev_short;
      r_err_line_long  <= (r_err_line_long  & ~clr_status) | w_ev_long;

      if (!cfg_enable) begin
        r_state <= ST_IDLE;
      end else if (w_chk) begin
        if (w_sof) begin
          r_lw <= cfg_line_words;
          r_fl <= cfg_frame_lines;
        end
        if (s_axis_tlast) begin
          r_word_cnt  <= '0;
          r_line_cnt  <= w_line_next;
          r_long_seen <= 1'b0;
          r_state     <= w_ev_done ? ST_IDLE : ST_IN_FRAME;
        end else begin
          r_word_cnt  <= w_word_this;
          r_line_cnt  <= w_line_this;
          r_long_seen <= w_long_seen | w_ev_long;
          r_state     <= ST_IN_FRAME;
        end
      end
    end
  end

  assign frame_done          = r_frame_done;
  assign stat_frame_cnt      = r_frame_cnt;
  assign stat_err_no_sof     = r_err_no_sof;
  assign stat_err_sof_early  = r_err_sof_early;
  assign stat_err_line_short = r_err_line_short;
  assign stat_err_line_long  = r_err_line_long;

endmodule

// File: tb/tb_xgs_axis_frame_checker.sv
// Directed bench for xgs_axis_frame_checker: a scoreboard queue tracks forwarded beats,
// immediate assertions check framing flags, counters and reset behaviour.
module tb_xgs_axis_frame_checker;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int CW = 16;

  typedef logic [DW+KW+1:0] beat_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tuser;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          cfg_enable;
  logic [CW-1:0] cfg_line_words;
  logic [CW-1:0] cfg_frame_lines;
  logic          clr_status;
  logic          frame_done;
  logic [31:0]   stat_frame_cnt;
  logic          stat_err_no_sof;
  logic          stat_err_sof_early;
  logic          stat_err_line_short;
  logic          stat_err_line_long;
  logic [3:0]    flags;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    ready_mode = 0;

  assign flags = {stat_err_no_sof, stat_err_sof_early, stat_err_line_short, stat_err_line_long};

  always #5 aclk = ~aclk;

  xgs_axis_frame_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .cfg_enable(cfg_enable), .cfg_line_words(cfg_line_words), .cfg_frame_lines(cfg_frame_lines),
    .clr_status(clr_status), .frame_done(frame_done), .stat_frame_cnt(stat_frame_cnt),
    .stat_err_no_sof(stat_err_no_sof), .stat_err_sof_early(stat_err_sof_early),
    .stat_err_line_short(stat_err_line_short), .stat_err_line_long(stat_err_line_long)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Downstream ready: 0 = always, 1 = random 50%, 2 = held low.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: pops the scoreboard on every transfer and checks stall stability.
  initial begin
    beat_t got;
    beat_t want;
    beat_t prev_beat;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_stall = 1'b0;
      end else begin
        got = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (prev_stall) begin
          check("stall_valid", m_axis_tvalid, 1'b1);
          check("stall_beat", got, prev_beat);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_beat", 32'(exp_q.size()), 32'd1);
          end else begin
            want = exp_q.pop_front();
            check("out_beat", got, want);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = got;
      end
    end
  end

  task automatic send(input logic u, input logic l);
    int n;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {$urandom, $urandom};
    s_axis_tkeep  = KW'($urandom);
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!s_axis_tready && n < 300);
    check("s_accept", s_axis_tready, 1'b1);
    if (s_axis_tready) exp_q.push_back({u, l, s_axis_tkeep, s_axis_tdata});
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_line(input int words, input logic sof);
    for (int i = 0; i < words; i++) send(sof && i == 0, i == words - 1);
  endtask

  task automatic send_frame(input int lines, input int words, input logic exp_done,
                            input logic clr_last);
    logic last_beat;
    for (int li = 0; li < lines; li++) begin
      for (int wi = 0; wi < words; wi++) begin
        last_beat = (li == lines - 1) && (wi == words - 1);
        if (last_beat && clr_last) clr_status = 1'b1;
        send(li == 0 && wi == 0, wi == words - 1);
        clr_status = 1'b0;
        if (last_beat) check("frame_done_pulse", frame_done, exp_done);
      end
    end
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    @(posedge aclk);
    #1;
    clr_status = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge aclk);
      n++;
    end
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    cfg_enable = 1'b1; cfg_line_words = 16'd4; cfg_frame_lines = 16'd3; clr_status = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_s_ready", s_axis_tready, 1'b0);
    check("rst_m_valid", m_axis_tvalid, 1'b0);
    check("rst_m_data", m_axis_tdata, 64'd0);
    check("rst_frame_cnt", stat_frame_cnt, 32'd0);
    check("rst_flags", flags, 4'b0000);
    check("rst_frame_done", frame_done, 1'b0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;
    check("rel_s_ready", s_axis_tready, 1'b1);

    // Clean 4x3 frame at full rate.
    send_frame(3, 4, 1'b1, 1'b0);
    @(posedge aclk); #1;
    check("t1_done_single_cycle", frame_done, 1'b0);
    wait_drain();
    check("t1_frame_cnt", stat_frame_cnt, 32'd1);
    check("t1_flags", flags, 4'b0000);

    // Two frames under random backpressure.
    pulse_clr();
    ready_mode = 1;
    send_frame(3, 4, 1'b1, 1'b0);
    send_frame(3, 4, 1'b1, 1'b0);
    wait_drain();
    ready_mode = 0;
    check("t2_frame_cnt", stat_frame_cnt, 32'd2);
    check("t2_flags", flags, 4'b0000);

    // Short line 1.
    pulse_clr();
    send_line(4, 1'b1);
    send(1'b0, 1'b0); send(1'b0, 1'b0);
    check("t3_short_before", stat_err_line_short, 1'b0);
    send(1'b0, 1'b1);
    check("t3_short_flag", flags, 4'b0010);
    send_line(4, 1'b0);
    check("t3_frame_done", frame_done, 1'b1);
    wait_drain();
    check("t3_frame_cnt", stat_frame_cnt, 32'd1);
    pulse_clr();
    check("t3_clr_flags", flags, 4'b0000);
    check("t3_clr_cnt", stat_frame_cnt, 32'd0);

    // Long line 0 (flag on its fourth beat), then an early SOF in line 2.
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0);
    check("t4_long_before", stat_err_line_long, 1'b0);
    send(1'b0, 1'b0);
    check("t4_long_on_4th", stat_err_line_long, 1'b1);
    send(1'b0, 1'b0); send(1'b0, 1'b1);
    send_line(4, 1'b0);
    send(1'b0, 1'b0); send(1'b0, 1'b0);
    check("t4_early_before", stat_err_sof_early, 1'b0);
    send(1'b1, 1'b0);
    check("t4_early_flag", stat_err_sof_early, 1'b1);
    send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b1);
    send_line(4, 1'b0);
    send_line(4, 1'b0);
    check("t4_frame_done", frame_done, 1'b1);
    wait_drain();
    check("t4_flags", flags, 4'b0101);
    check("t4_frame_cnt", stat_frame_cnt, 32'd1);
    pulse_clr();

    // Beats without SOF, then reset with a full buffer.
    send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0);
    check("t5_no_sof", flags, 4'b1000);
    wait_drain();
    ready_mode = 2;
    repeat (2) @(posedge aclk);
    #1;
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    check("t5_buffer_full", s_axis_tready, 1'b0);
    check("t5_out_held", m_axis_tvalid, 1'b1);
    areset = 1'b1;
    @(posedge aclk);
    exp_q.delete();
    @(negedge aclk);
    check("t5_rst_s_ready", s_axis_tready, 1'b0);
    check("t5_rst_m_valid", m_axis_tvalid, 1'b0);
    check("t5_rst_m_data", m_axis_tdata, 64'd0);
    check("t5_rst_flags", flags, 4'b0000);
    check("t5_rst_cnt", stat_frame_cnt, 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    ready_mode = 0;
    @(posedge aclk); #1;
    check("t5_rel_s_ready", s_axis_tready, 1'b1);
    check("t5_rel_m_valid", m_axis_tvalid, 1'b0);

    // Checker disabled: data passes, nothing counted.
    cfg_enable = 1'b0;
    send_frame(3, 4, 1'b0, 1'b0);
    wait_drain();
    check("t6_dis_cnt", stat_frame_cnt, 32'd0);
    check("t6_dis_flags", flags, 4'b0000);
    cfg_enable = 1'b1;
    @(posedge aclk); #1;
    send_frame(3, 4, 1'b1, 1'b0);
    check("t6_cnt_before_clr", stat_frame_cnt, 32'd1);
    send_frame(3, 4, 1'b1, 1'b1);
    check("t6_clr_vs_done", stat_frame_cnt, 32'd1);
    check("t6_flags", flags, 4'b0000);

    // frame_lines = 0 never completes; the next SOF arrives mid-frame.
    cfg_frame_lines = 16'd0;
    send_frame(3, 4, 1'b0, 1'b0);
    check("t7_fl0_cnt", stat_frame_cnt, 32'd1);
    cfg_frame_lines = 16'd3;
    send_frame(3, 4, 1'b1, 1'b0);
    check("t7_cnt", stat_frame_cnt, 32'd2);
    check("t7_flags", flags, 4'b0100);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
